// File: rtl/vga_pkg.sv
// vga_pkg: shared frame-buffer geometry, RGB111 color constants and painter states.
package vga_pkg;
  localparam int AW = 8;
  localparam int DW = 3;
  localparam int GRID_W = 16;
  localparam int GRID_H = 12;
  localparam int px_scale = 64;
  localparam logic [2:0] RED_VGA = 3'b100;
  localparam logic [2:0] GREEN_VGA = 3'b010;
  localparam logic [2:0] BLUE_VGA = 3'b001;
  typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-FF sync, optional debounce (CELL_PAINTER_DEBOUNCE_EN), one-cycle rising-edge pulse.
module button_conditioner #(
  parameter int DB_CYCLES = 750000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic s1_q, s2_q, prev_q, pulse_q, pulse_d, level;
`ifdef CELL_PAINTER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic db_q, db_d, last;
  always_comb begin
    last = (s2_q != db_q) && (cnt_q == CW'(DB_CYCLES - 1));
    cnt_d = (s2_q == db_q || last) ? '0 : cnt_q + 1'b1;
    db_d = last ? s2_q : db_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      db_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q <= db_d;
    end
  assign level = db_q;
`else
  localparam int unused_db = DB_CYCLES;
  assign level = s2_q;
`endif
  always_comb pulse_d = level & ~prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      prev_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      prev_q <= level;
      pulse_q <= pulse_d;
    end
  assign pulse = pulse_q;
endmodule

// File: rtl/cell_painter.sv
// cell_painter: clears the cell frame buffer, then moves a cursor on button presses and paints it.
// Debounce is present when CELL_PAINTER_DEBOUNCE_EN is defined.
module cell_painter #(
  parameter int AW = 8,
  parameter int DW = 3,
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int DB_CYCLES = 750000,
  parameter logic [DW-1:0] CLEAR_COLOR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bntr,
  input  logic          bntl,
  input  logic [DW-1:0] switch,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic [AW-1:0] cursor,
  output logic          busy
);
  import vga_pkg::*;
  localparam int N = GRID_W * GRID_H;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  state_t state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d, cursor_q, cursor_d, addr_q, addr_d, nxt;
  logic [DW-1:0] data_q, data_d;
  logic we_q, we_d, busy_q, busy_d, pr, pl;
  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_right (.clk(clk), .rst(rst), .btn(bntr), .pulse(pr));
  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_left (.clk(clk), .rst(rst), .btn(bntl), .pulse(pl));
  always_comb begin
    nxt = (pr && !pl) ? ((cursor_q == LAST) ? '0 : cursor_q + 1'b1) :
          (pl && !pr) ? ((cursor_q == '0) ? LAST : cursor_q - 1'b1) : cursor_q;
    state_d = state_q;
    clr_idx_d = clr_idx_q;
    cursor_d = cursor_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d = 1'b0;
    busy_d = busy_q;
    case (state_q)
      CLEAR: begin
        if (we_q && addr_q == LAST) begin
          state_d = IDLE;
          busy_d = 1'b0;
        end else begin
          we_d = 1'b1;
          addr_d = clr_idx_q;
          data_d = CLEAR_COLOR;
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      IDLE: if (pr || pl) begin
        state_d = WRITE;
        cursor_d = nxt;
        addr_d = nxt;
        data_d = switch;
        we_d = 1'b1;
      end
      WRITE: state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
      cursor_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
      cursor_q <= cursor_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      busy_q <= busy_d;
    end
  assign addr_in = addr_q;
  assign data_in = data_q;
  assign regwrite = we_q;
  assign cursor = cursor_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_cell_painter.sv
// tb_cell_painter: randomized button presses checked against a modular-arithmetic cursor model and write log.
`timescale 1ns/1ps
module tb_cell_painter;
  localparam int AW = 8, DW = 3, N = 192, DB = 4;
`ifdef CELL_PAINTER_DEBOUNCE_EN
  localparam int LAT = DB + 4;
`else
  localparam int LAT = 4;
`endif
  logic clk = 1'b0, rst = 1'b1, bntr = 1'b0, bntl = 1'b0;
  logic [DW-1:0] switch_i = '0;
  logic [AW-1:0] addr_in, cursor;
  logic [DW-1:0] data_in;
  logic regwrite, busy;
  int checks = 0, errors = 0, exp_cursor = 0;
  logic [AW+DW-1:0] wq[$];

  always #5 clk = ~clk;

  cell_painter #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .bntr(bntr), .bntl(bntl), .switch(switch_i),
    .addr_in(addr_in), .data_in(data_in), .regwrite(regwrite), .cursor(cursor), .busy(busy)
  );

  always @(negedge clk) if (!rst && regwrite) wq.push_back({addr_in, data_in});

  task automatic check_sweep();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      checks++;
      if (regwrite !== 1'b1 || addr_in !== AW'(i) || data_in !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL sweep[%0d]: we=%b addr=%0d data=%0d busy=%b, want we=1 addr=%0d data=0 busy=1",
                 i, regwrite, addr_in, data_in, busy, i);
      end
    end
    @(negedge clk);
    checks++;
    if (regwrite !== 1'b0 || busy !== 1'b0 || cursor !== '0) begin
      errors++;
      $display("FAIL sweep_end: we=%b busy=%b cursor=%0d, want we=0 busy=0 cursor=0", regwrite, busy, cursor);
    end
  endtask

  task automatic press(input bit r, input bit l, input logic [DW-1:0] c);
    int n, want;
    want = (r && !l) ? (exp_cursor + 1) % N : (l && !r) ? (exp_cursor + N - 1) % N : exp_cursor;
    wq.delete();
    switch_i = c;
    bntr = r;
    bntl = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (regwrite !== 1'b1 && n < 50);
    switch_i = ~c;
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL press_latency r=%0b l=%0b: got %0d cycles, want %0d", r, l, n, LAT);
    end
    repeat (8) @(negedge clk);
    bntr = 1'b0;
    bntl = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    exp_cursor = want;
    checks++;
    if (wq.size() != 1 || wq[0] !== {AW'(want), c} || cursor !== AW'(want)) begin
      errors++;
      $display("FAIL press_write r=%0b l=%0b: writes=%0d first=%h cursor=%0d, want writes=1 addr=%0d data=%0d cursor=%0d",
               r, l, wq.size(), (wq.size() > 0) ? wq[0] : '1, cursor, want, c, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cursor !== '0 || addr_in !== '0 || data_in !== '0 || regwrite !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: cursor=%0d addr=%0d data=%0d we=%b busy=%b, want 0 0 0 0 1",
               cursor, addr_in, data_in, regwrite, busy);
    end
    rst = 1'b0;
    exp_cursor = 0;
    check_sweep();
  endtask

  task automatic test_right();
    press(1'b1, 1'b0, 3'b100);
  endtask

  task automatic test_wrap();
    press(1'b0, 1'b1, 3'b001);
    press(1'b0, 1'b1, 3'b010);
    press(1'b1, 1'b0, 3'b001);
  endtask

  task automatic test_glitch();
`ifdef CELL_PAINTER_DEBOUNCE_EN
    wq.delete();
    for (int i = 0; i < 6; i++) begin
      bntr = 1'b1;
      repeat (2) @(negedge clk);
      bntr = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if (wq.size() != 0 || cursor !== AW'(exp_cursor)) begin
      errors++;
      $display("FAIL glitch: writes=%0d cursor=%0d, want writes=0 cursor=%0d", wq.size(), cursor, exp_cursor);
    end
`endif
  endtask

  task automatic test_both();
    press(1'b1, 1'b1, 3'b111);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      press(sel != 1, sel != 0, DW'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_clear_press();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wq.delete();
    rst = 1'b0;
    exp_cursor = 0;
    fork
      check_sweep();
      begin
        repeat (10) @(negedge clk);
        bntr = 1'b1;
        repeat (LAT + 6) @(negedge clk);
        bntr = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    checks++;
    if (wq.size() != N || cursor !== '0) begin
      errors++;
      $display("FAIL clear_press: writes=%0d cursor=%0d, want writes=%0d cursor=0", wq.size(), cursor, N);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cursor = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(regwrite === 1'b1 && addr_in === AW'(50)) && n < 300);
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL reset_mid_wait: sweep index 50 not seen in %0d cycles, want within 300", n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (regwrite !== 1'b0 || addr_in !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_abort: we=%b addr=%0d busy=%b, want we=0 addr=0 busy=1", regwrite, addr_in, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_sweep();
  endtask

  initial begin
    test_reset();
    test_right();
    test_wrap();
    test_glitch();
    test_both();
    test_random();
    test_clear_press();
    test_reset_mid();
    test_right();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
